// File: rtl/game_ui_pkg.sv
// Shared definitions for the game-UI sequencer slice.
// Holds the controller state encoding, the UI entry field widths and the
// default fetch timeout, plus the saturating health subtract used by the
// health tracker.
package game_ui_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_END   = 2'd3
   } ui_state_t;

   localparam int GEOM_W            = 10;  // bar x/y/w/h, character amount
   localparam int HEALTH_W          = 10;  // health current/max, damage
   localparam int SENS_W            = 7;   // bar sensitivity
   localparam int FETCH_TIMEOUT_DEF = 16;

   // Health never goes below zero: any hit at least as large as the
   // remaining health leaves exactly 0.
   function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] health,
                                                   input logic [HEALTH_W-1:0] dmg);
      return (dmg >= health) ? '0 : health - dmg;
   endfunction

endpackage

// File: rtl/game_ui_sequencer_health.sv
// ui_health_tracker: live player health register.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   active            controller is in FETCH or HOLD (damage/death enabled)
//   load, load_value  entry latch from the reader; wins over damage
//   damage_valid/amt  damage strobe and amount
//   health            live ui_health_current
//   dead              player_dead level (health == 0 while active)
//   dead_rise         first cycle dead is high
module ui_health_tracker
   import game_ui_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                active,
   input  logic                load,
   input  logic [HEALTH_W-1:0] load_value,
   input  logic                damage_valid,
   input  logic [HEALTH_W-1:0] damage_amount,
   output logic [HEALTH_W-1:0] health,
   output logic                dead,
   output logic                dead_rise
);

   logic dead_q;

   assign dead      = active && (health == '0);
   // Edge-detected so that restarting into FETCH with health still 0, or
   // loading an entry that itself carries 0 health, cannot loop restarts.
   assign dead_rise = dead && !dead_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         health <= '0;
         dead_q <= 1'b0;
      end else begin
         dead_q <= dead;
         if (load)
            health <= load_value;               // damage on this edge is dropped
         else if (active && damage_valid)
            health <= sat_sub(health, damage_amount);
      end
   end

endmodule

// File: rtl/game_ui_sequencer.sv
// game_ui_sequencer: controller around the game-UI ROM reader.
// Owns the UI timebase and ROM address, hands the reader its fetch window
// through sync_ui_time, latches each decoded entry as live UI state, applies
// damage, and restarts or ends the script according to entry flags.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start, time_tick             script start pulse, timebase strobe
//   damage_valid/damage_amount   damage event
//   addr, current_time           ROM address and timebase to the reader
//   sync_ui_time                 1 = reader idles, 0 = reader may fetch
//   update_ui_time, rd_*         decoded entry from the reader
//   ui_*                         live UI state for the renderers
//   character_reset_pulse        one cycle per entry with reset_character set
//   player_dead, game_end        status levels
//   fetch_error                  sticky reader-timeout flag
module game_ui_sequencer
   import game_ui_pkg::*;
#(
   parameter int ADDR_WIDTH    = 10,
   parameter int MAXIMUM_TIMES = 30,
   parameter int FETCH_TIMEOUT = FETCH_TIMEOUT_DEF
)(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     time_tick,
   input  logic                     damage_valid,
   input  logic [HEALTH_W-1:0]      damage_amount,
   output logic [ADDR_WIDTH-1:0]    addr,
   output logic [MAXIMUM_TIMES-1:0] current_time,
   output logic                     sync_ui_time,
   input  logic                     update_ui_time,
   input  logic                     rd_reset_character,
   input  logic [GEOM_W-1:0]        rd_character_amount,
   input  logic [HEALTH_W-1:0]      rd_health_current,
   input  logic [HEALTH_W-1:0]      rd_health_max,
   input  logic                     rd_transparent,
   input  logic                     rd_reset_when_dead,
   input  logic [GEOM_W-1:0]        rd_bar_x,
   input  logic [GEOM_W-1:0]        rd_bar_y,
   input  logic [GEOM_W-1:0]        rd_bar_w,
   input  logic [GEOM_W-1:0]        rd_bar_h,
   input  logic [SENS_W-1:0]        rd_bar_sensitivity,
   input  logic [MAXIMUM_TIMES-1:0] rd_next_ui_time,
   input  logic                     rd_is_end,
   output logic [GEOM_W-1:0]        ui_character_amount,
   output logic [HEALTH_W-1:0]      ui_health_current,
   output logic [HEALTH_W-1:0]      ui_health_max,
   output logic [GEOM_W-1:0]        ui_bar_x,
   output logic [GEOM_W-1:0]        ui_bar_y,
   output logic [GEOM_W-1:0]        ui_bar_w,
   output logic [GEOM_W-1:0]        ui_bar_h,
   output logic [SENS_W-1:0]        ui_bar_sensitivity,
   output logic                     ui_transparent,
   output logic                     character_reset_pulse,
   output logic                     player_dead,
   output logic                     game_end,
   output logic                     fetch_error
);

   localparam int             CNT_W   = $clog2(FETCH_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(FETCH_TIMEOUT);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(FETCH_TIMEOUT - 1);

   ui_state_t                state, state_nxt;
   logic [MAXIMUM_TIMES-1:0] next_time;
   logic                     reset_when_dead;
   logic [CNT_W-1:0]         to_cnt;

   logic in_fetch, in_hold, active;
   logic launch, latch, advance, restart, dead_rise;

   assign in_fetch = (state == ST_FETCH);
   assign in_hold  = (state == ST_HOLD);
   assign active   = in_fetch || in_hold;

   // Reader handshake is purely state driven: it may fetch only in FETCH.
   // Address and state move on the same edge, so the reader never samples
   // a stale address when sync drops.
   assign sync_ui_time = !in_fetch;
   assign game_end     = (state == ST_END);

   assign launch  = start && (state == ST_IDLE || state == ST_END);
   assign latch   = in_fetch && update_ui_time;
   assign restart = in_hold && dead_rise && reset_when_dead;
   assign advance = in_hold && !restart && (current_time >= next_time);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE, ST_END: if (start)          state_nxt = ST_FETCH;
         ST_FETCH:        if (update_ui_time) state_nxt = rd_is_end ? ST_END : ST_HOLD;
         ST_HOLD:         if (restart || advance) state_nxt = ST_FETCH;
         default:         state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- address / timebase ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr         <= '0;
         current_time <= '0;
      end else begin
         if (launch || restart)
            addr <= '0;
         else if (advance)
            addr <= addr + 1'b1;              // wraps to 0 past the last entry

         if (launch || restart)
            current_time <= '0;
         else if (active && time_tick)
            current_time <= current_time + 1'b1;
      end
   end

   // ---------------- entry latch ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ui_character_amount   <= '0;
         ui_health_max         <= '0;
         ui_bar_x              <= '0;
         ui_bar_y              <= '0;
         ui_bar_w              <= '0;
         ui_bar_h              <= '0;
         ui_bar_sensitivity    <= '0;
         ui_transparent        <= 1'b0;
         next_time             <= '0;
         reset_when_dead       <= 1'b0;
         character_reset_pulse <= 1'b0;
      end else begin
         character_reset_pulse <= latch && rd_reset_character;
         if (latch) begin
            ui_character_amount <= rd_character_amount;
            ui_health_max       <= rd_health_max;
            ui_bar_x            <= rd_bar_x;
            ui_bar_y            <= rd_bar_y;
            ui_bar_w            <= rd_bar_w;
            ui_bar_h            <= rd_bar_h;
            ui_bar_sensitivity  <= rd_bar_sensitivity;
            ui_transparent      <= rd_transparent;
            next_time           <= rd_next_ui_time;
            reset_when_dead     <= rd_reset_when_dead;
         end
      end
   end

   // ---------------- reader timeout ----------------
   // Counter only runs while waiting in FETCH and saturates at the limit;
   // the error flag is sticky until reset and does not change state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt      <= '0;
         fetch_error <= 1'b0;
      end else begin
         if (!in_fetch || latch)
            to_cnt <= '0;
         else if (to_cnt != TO_MAX)
            to_cnt <= to_cnt + 1'b1;

         if (in_fetch && !latch && to_cnt == TO_LAST)
            fetch_error <= 1'b1;
      end
   end

   // ---------------- health ----------------
   ui_health_tracker u_health (
      .clk          (clk),
      .reset_n      (reset_n),
      .active       (active),
      .load         (latch),
      .load_value   (rd_health_current),
      .damage_valid (damage_valid),
      .damage_amount(damage_amount),
      .health       (ui_health_current),
      .dead         (player_dead),
      .dead_rise    (dead_rise)
   );

endmodule
